// File: rtl/reorder_buffer_if.sv
// ---------------------------------------------------------------------------
// reorder_buffer_if
// Bundles the issue, writeback, operand-lookup and commit/flush signals of the
// reorder buffer.
//   slave  : the reorder buffer itself
//   master : the surrounding pipeline (issue stage, writeback bus, regfile)
// Issue     : issue_valid, issue_rd, issue_is_branch -> issue_rob_id, full
// Writeback : wb_valid, wb_rob_id, wb_val, wb_mispredict, wb_target
// Lookup    : search_rob_id_1/2 -> search_ready_1/2, search_val_1/2
// Commit    : commit_reg_id, commit_val, commit_rob_id, clear, redirect_pc
// ---------------------------------------------------------------------------
interface reorder_buffer_if #(
    parameter int ROB_WIDTH = 3
);
    logic                 issue_valid;
    logic [4:0]           issue_rd;
    logic                 issue_is_branch;
    logic [ROB_WIDTH-1:0] issue_rob_id;
    logic                 full;

    logic                 wb_valid;
    logic [ROB_WIDTH-1:0] wb_rob_id;
    logic [31:0]          wb_val;
    logic                 wb_mispredict;
    logic [31:0]          wb_target;

    logic [ROB_WIDTH-1:0] search_rob_id_1;
    logic [ROB_WIDTH-1:0] search_rob_id_2;
    logic                 search_ready_1;
    logic                 search_ready_2;
    logic [31:0]          search_val_1;
    logic [31:0]          search_val_2;

    logic [4:0]           commit_reg_id;
    logic [31:0]          commit_val;
    logic [ROB_WIDTH-1:0] commit_rob_id;
    logic                 clear;
    logic [31:0]          redirect_pc;

    modport slave (
        input  issue_valid, issue_rd, issue_is_branch,
        output issue_rob_id, full,
        input  wb_valid, wb_rob_id, wb_val, wb_mispredict, wb_target,
        input  search_rob_id_1, search_rob_id_2,
        output search_ready_1, search_ready_2, search_val_1, search_val_2,
        output commit_reg_id, commit_val, commit_rob_id, clear, redirect_pc
    );

    modport master (
        output issue_valid, issue_rd, issue_is_branch,
        input  issue_rob_id, full,
        output wb_valid, wb_rob_id, wb_val, wb_mispredict, wb_target,
        output search_rob_id_1, search_rob_id_2,
        input  search_ready_1, search_ready_2, search_val_1, search_val_2,
        input  commit_reg_id, commit_val, commit_rob_id, clear, redirect_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
// Circular in-order reorder buffer. Allocates one entry per issued op at the
// tail, captures writeback results, answers operand lookups by ROB id and
// retires the head in order, driving the regfile commit port. Retiring a
// mispredicted branch flushes everything with a one-cycle clear pulse plus a
// redirect PC.
// Ports:
//   clk_in  : clock, all state updates on the rising edge
//   rst_in  : synchronous reset, active low
//   rdy_in  : low freezes all state and registered outputs
//   bus     : reorder_buffer_if.slave (issue / writeback / lookup / commit)
// ---------------------------------------------------------------------------
module reorder_buffer #(
    parameter int ROB_WIDTH = 3
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    reorder_buffer_if.slave  bus
);
    localparam int DEPTH = 2 ** ROB_WIDTH;
    localparam logic [ROB_WIDTH-1:0] IDX_ONE  = 1;
    localparam logic [ROB_WIDTH:0]   CNT_ONE  = 1;
    localparam logic [ROB_WIDTH:0]   CNT_FULL = (ROB_WIDTH+1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t               state_reg;
    logic [ROB_WIDTH-1:0] head_reg;
    logic [ROB_WIDTH-1:0] tail_reg;
    logic [ROB_WIDTH:0]   count_reg;

    // Per-entry flags (reset) and payload (never reset: only meaningful
    // while the matching flag is set).
    logic [DEPTH-1:0]     busy_reg;
    logic [DEPTH-1:0]     ready_reg;
    logic [DEPTH-1:0]     mispredict_reg;
    logic [DEPTH-1:0]     is_branch_reg;
    logic [4:0]           rd_mem     [DEPTH];
    logic [31:0]          val_mem    [DEPTH];
    logic [31:0]          target_mem [DEPTH];

    logic [4:0]           commit_reg_id_reg;
    logic [31:0]          commit_val_reg;
    logic [ROB_WIDTH-1:0] commit_rob_id_reg;
    logic                 clear_reg;
    logic [31:0]          redirect_pc_reg;
    logic [31:0]          flush_target_reg;

    logic                 full_int;
    logic                 do_issue;
    logic                 do_wb;
    logic                 do_commit;

    assign full_int  = (count_reg == CNT_FULL) || (state_reg != ST_RUN);
    // The clear cycle already runs in ST_RUN, so issue is blocked separately.
    assign do_issue  = bus.issue_valid && !full_int && !clear_reg;
    assign do_wb     = bus.wb_valid && busy_reg[bus.wb_rob_id];
    // Commit looks only at the registered ready bit: a result written back
    // in one cycle retires at the earliest one edge later.
    assign do_commit = (state_reg == ST_RUN) && busy_reg[head_reg] && ready_reg[head_reg];

    // ------------------------------------------------------------------
    // Operand lookup, two identical ports with writeback bypass.
    // ready/val are not cleared on retire, so a consumer can still read a
    // value in the cycle between retire and the regfile update.
    // ------------------------------------------------------------------
    logic [ROB_WIDTH-1:0] search_id  [2];
    logic                 search_rdy [2];
    logic [31:0]          search_v   [2];

    assign search_id[0] = bus.search_rob_id_1;
    assign search_id[1] = bus.search_rob_id_2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_search
            logic bypass;
            assign bypass = bus.wb_valid && (bus.wb_rob_id == search_id[gi])
                            && busy_reg[search_id[gi]];
            assign search_rdy[gi] = ready_reg[search_id[gi]] || bypass;
            assign search_v[gi]   = bypass                   ? bus.wb_val :
                                    ready_reg[search_id[gi]] ? val_mem[search_id[gi]] :
                                                               32'd0;
        end
    endgenerate

    assign bus.search_ready_1 = search_rdy[0];
    assign bus.search_ready_2 = search_rdy[1];
    assign bus.search_val_1   = search_v[0];
    assign bus.search_val_2   = search_v[1];

    // ------------------------------------------------------------------
    // Control state: pointers, flags, FSM and registered commit outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_reg         <= ST_RUN;
            head_reg          <= '0;
            tail_reg          <= '0;
            count_reg         <= '0;
            busy_reg          <= '0;
            ready_reg         <= '0;
            mispredict_reg    <= '0;
            commit_reg_id_reg <= '0;
            commit_val_reg    <= '0;
            commit_rob_id_reg <= '0;
            clear_reg         <= 1'b0;
            redirect_pc_reg   <= '0;
            flush_target_reg  <= '0;
        end else if (rdy_in) begin
            case (state_reg)
                ST_FLUSH: begin
                    // The mispredicted branch already retired; drop everything
                    // younger and steer fetch to the corrected PC.
                    state_reg         <= ST_RUN;
                    clear_reg         <= 1'b1;
                    redirect_pc_reg   <= flush_target_reg;
                    busy_reg          <= '0;
                    ready_reg         <= '0;
                    mispredict_reg    <= '0;
                    head_reg          <= '0;
                    tail_reg          <= '0;
                    count_reg         <= '0;
                    commit_reg_id_reg <= '0;
                end
                default: begin
                    clear_reg <= 1'b0;

                    if (do_wb) begin
                        ready_reg[bus.wb_rob_id]      <= 1'b1;
                        mispredict_reg[bus.wb_rob_id] <= bus.wb_mispredict
                                                         && is_branch_reg[bus.wb_rob_id];
                    end

                    // Tail slot is never busy here, so it cannot collide
                    // with the writeback target above.
                    if (do_issue) begin
                        busy_reg[tail_reg]       <= 1'b1;
                        ready_reg[tail_reg]      <= 1'b0;
                        mispredict_reg[tail_reg] <= 1'b0;
                        tail_reg                 <= tail_reg + IDX_ONE;
                    end

                    if (do_commit) begin
                        commit_reg_id_reg  <= rd_mem[head_reg];
                        commit_val_reg     <= val_mem[head_reg];
                        commit_rob_id_reg  <= head_reg;
                        busy_reg[head_reg] <= 1'b0;
                        head_reg           <= head_reg + IDX_ONE;
                        if (mispredict_reg[head_reg]) begin
                            state_reg        <= ST_FLUSH;
                            flush_target_reg <= target_mem[head_reg];
                        end
                    end else begin
                        commit_reg_id_reg <= '0;
                    end

                    if (do_issue && !do_commit) begin
                        count_reg <= count_reg + CNT_ONE;
                    end else if (!do_issue && do_commit) begin
                        count_reg <= count_reg - CNT_ONE;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Entry payload storage.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            if (do_wb) begin
                val_mem[bus.wb_rob_id]    <= bus.wb_val;
                target_mem[bus.wb_rob_id] <= bus.wb_target;
            end
            if (do_issue) begin
                rd_mem[tail_reg]        <= bus.issue_rd;
                is_branch_reg[tail_reg] <= bus.issue_is_branch;
            end
        end
    end

    assign bus.issue_rob_id  = tail_reg;
    assign bus.full          = full_int;
    assign bus.commit_reg_id = commit_reg_id_reg;
    assign bus.commit_val    = commit_val_reg;
    assign bus.commit_rob_id = commit_rob_id_reg;
    assign bus.clear         = clear_reg;
    assign bus.redirect_pc   = redirect_pc_reg;

endmodule

// File: tb/tb_reorder_buffer.sv
// ---------------------------------------------------------------------------
// tb_reorder_buffer
// Scoreboard bench for reorder_buffer. The reference model keeps the in-flight
// ops as a program-ordered queue; retirement order follows from it directly.
// A monitor process pops expected commits/flushes whenever the DUT shows one.
// ---------------------------------------------------------------------------
module tb_reorder_buffer;
    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    always #5 clk_in = ~clk_in;

    reorder_buffer_if #(.ROB_WIDTH(3)) bus ();

    reorder_buffer #(.ROB_WIDTH(3)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    typedef struct {
        logic [4:0]  rd;
        logic        br;
        logic [2:0]  id;
        bit          done;
        logic [31:0] val;
        bit          mp;
        logic [31:0] tgt;
    } op_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
        logic [2:0]  id;
    } commit_t;

    op_t         live[$];
    commit_t     exp_q[$];
    logic [31:0] flush_q[$];
    logic [2:0]  m_tail;
    bit          mp_pending;
    bit          stop_retire;
    bit          slot_ready[8];
    logic [31:0] slot_val[8];

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    function automatic void model_reset();
        live.delete();
        m_tail      = '0;
        mp_pending  = 1'b0;
        stop_retire = 1'b0;
        for (int i = 0; i < 8; i++) slot_ready[i] = 1'b0;
    endfunction

    // Retire in program order every op at the front that has its result;
    // a mispredicted branch retires and then everything behind it is dropped.
    function automatic void retire_model();
        while (!stop_retire && live.size() > 0 && live[0].done) begin
            op_t     o;
            commit_t c;
            o     = live.pop_front();
            c.rd  = o.rd;
            c.val = o.val;
            c.id  = o.id;
            exp_q.push_back(c);
            if (o.mp) begin
                flush_q.push_back(o.tgt);
                stop_retire = 1'b1;
            end
        end
    endfunction

    task automatic check_search(input string name, input logic [2:0] s, input logic act_rdy,
                                input logic [31:0] act_val, input bit wv, input logic [2:0] wid,
                                input logic [31:0] wval);
        logic        e_rdy;
        logic [31:0] e_val;
        if (wv && wid == s) begin
            e_rdy = 1'b1;
            e_val = wval;
        end else if (slot_ready[s]) begin
            e_rdy = 1'b1;
            e_val = slot_val[s];
        end else begin
            e_rdy = 1'b0;
            e_val = 32'd0;
        end
        check({name, "_ready"}, 32'(act_rdy), 32'(e_rdy));
        check({name, "_val"}, act_val, e_val);
    endtask

    // One clock cycle of stimulus, applied at the falling edge.
    task automatic cyc(input bit rdy, input bit iv, input logic [4:0] rd, input bit br,
                       input int widx, input logic [31:0] wval, input bit wmp,
                       input logic [31:0] wtgt, input logic [2:0] s1, input logic [2:0] s2);
        logic [2:0] wid;
        bit         wv;
        op_t        o;
        wv  = (widx >= 0);
        wid = wv ? live[widx].id : 3'($urandom);
        rdy_in              = rdy;
        bus.issue_valid     = iv;
        bus.issue_rd        = rd;
        bus.issue_is_branch = br;
        bus.wb_valid        = wv;
        bus.wb_rob_id       = wid;
        bus.wb_val          = wval;
        bus.wb_mispredict   = wmp;
        bus.wb_target       = wtgt;
        bus.search_rob_id_1 = s1;
        bus.search_rob_id_2 = s2;
        #1;
        check_search("search1", s1, bus.search_ready_1, bus.search_val_1, wv, wid, wval);
        check_search("search2", s2, bus.search_ready_2, bus.search_val_2, wv, wid, wval);
        if (rdy) begin
            if (iv && !bus.full && !bus.clear) begin
                check("issue_rob_id", 32'(bus.issue_rob_id), 32'(m_tail));
                o.rd   = rd;
                o.br   = br;
                o.id   = m_tail;
                o.done = 1'b0;
                o.val  = '0;
                o.mp   = 1'b0;
                o.tgt  = '0;
                live.push_back(o);
                slot_ready[m_tail] = 1'b0;
                m_tail = m_tail + 3'd1;
            end
            if (wv) begin
                live[widx].done = 1'b1;
                live[widx].val  = wval;
                live[widx].mp   = wmp && live[widx].br;
                live[widx].tgt  = wtgt;
                slot_ready[wid] = 1'b1;
                slot_val[wid]   = wval;
                if (live[widx].mp) mp_pending = 1'b1;
                retire_model();
            end
        end
        @(posedge clk_in);
        @(negedge clk_in);
        if (stop_retire && bus.clear) model_reset();
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 5'd0, 1'b0, -1, 32'd0, 1'b0, 32'd0, 3'($urandom), 3'($urandom));
    endtask

    task automatic issue(input logic [4:0] rd, input bit br);
        cyc(1'b1, 1'b1, rd, br, -1, 32'd0, 1'b0, 32'd0, 3'($urandom), 3'($urandom));
    endtask

    task automatic wb(input int idx, input logic [31:0] val, input bit mp, input logic [31:0] tgt);
        cyc(1'b1, 1'b0, 5'd0, 1'b0, idx, val, mp, tgt, 3'($urandom), 3'($urandom));
    endtask

    task automatic settle();
        int n = 0;
        while ((exp_q.size() != 0 || flush_q.size() != 0 || stop_retire) && n < 40) begin
            idle();
            n++;
        end
        check("settle_drained", 32'(exp_q.size() + flush_q.size()), 32'd0);
    endtask

    // Write back every outstanding op (random order), then let them retire.
    task automatic drain();
        int cand[$];
        int guard = 0;
        forever begin
            cand.delete();
            for (int i = 0; i < live.size(); i++) if (!live[i].done) cand.push_back(i);
            if (cand.size() == 0 || guard > 64) break;
            wb(cand[$urandom_range(0, cand.size() - 1)], $urandom, 1'b0, 32'd0);
            guard++;
        end
        settle();
    endtask

    task automatic do_reset();
        check("queues_empty_before_reset", 32'(exp_q.size() + flush_q.size()), 32'd0);
        exp_q.delete();
        flush_q.delete();
        rst_in          = 1'b0;
        rdy_in          = 1'b1;
        bus.issue_valid = 1'b0;
        bus.wb_valid    = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        model_reset();
    endtask

    // Monitor: consumes one expected commit / flush per DUT presentation.
    initial begin : monitor
        bit          r;
        commit_t     c;
        logic [31:0] t;
        forever begin
            @(posedge clk_in);
            r = rdy_in && rst_in;
            #2;
            if (r) begin
                if (bus.commit_reg_id != 5'd0) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_commit: got rd=%0d id=%0d, want no commit",
                                 bus.commit_reg_id, bus.commit_rob_id);
                    end else begin
                        c = exp_q.pop_front();
                        check("commit_reg_id", 32'(bus.commit_reg_id), 32'(c.rd));
                        check("commit_val", bus.commit_val, c.val);
                        check("commit_rob_id", 32'(bus.commit_rob_id), 32'(c.id));
                    end
                end
                if (bus.clear) begin
                    if (flush_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_clear: got clear=1 pc=0x%0h, want clear=0",
                                 bus.redirect_pc);
                    end else begin
                        t = flush_q.pop_front();
                        check("redirect_pc", bus.redirect_pc, t);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int wait_cnt;
        int cand[$];
        int mpk;
        int widx;
        bit iv;

        rst_in              = 1'b0;
        rdy_in              = 1'b1;
        bus.issue_valid     = 1'b0;
        bus.issue_rd        = '0;
        bus.issue_is_branch = 1'b0;
        bus.wb_valid        = 1'b0;
        bus.wb_rob_id       = '0;
        bus.wb_val          = '0;
        bus.wb_mispredict   = 1'b0;
        bus.wb_target       = '0;
        bus.search_rob_id_1 = '0;
        bus.search_rob_id_2 = '0;

        // 1: reset state
        do_reset();
        check("reset_full", 32'(bus.full), 32'd0);
        check("reset_issue_rob_id", 32'(bus.issue_rob_id), 32'd0);
        check("reset_commit_reg_id", 32'(bus.commit_reg_id), 32'd0);
        check("reset_clear", 32'(bus.clear), 32'd0);
        check("reset_redirect_pc", bus.redirect_pc, 32'd0);

        // 2: single op, commit one edge after writeback
        issue(5'd5, 1'b0);
        wb(0, 32'h1234, 1'b0, 32'd0);
        check("t2_no_commit_at_wb_edge", 32'(bus.commit_reg_id), 32'd0);
        idle();
        check("t2_commit_next_edge", 32'(bus.commit_reg_id), 32'd5);
        settle();

        // 3: fill, overflow attempt, free one slot
        do_reset();
        for (int i = 0; i < 8; i++) issue(5'(i + 1), 1'b0);
        check("t3_full_after_8", 32'(bus.full), 32'd1);
        issue(5'd20, 1'b0);
        check("t3_ninth_ignored_id", 32'(bus.issue_rob_id), 32'(m_tail));
        check("t3_still_full", 32'(bus.full), 32'd1);
        wb(0, 32'hA0, 1'b0, 32'd0);
        check("t3_full_until_commit", 32'(bus.full), 32'd1);
        idle();
        check("t3_full_drops", 32'(bus.full), 32'd0);
        check("t3_id_reused", 32'(bus.issue_rob_id), 32'd0);
        drain();

        // 4: out-of-order writeback, in-order commit
        do_reset();
        issue(5'd3, 1'b0);
        issue(5'd4, 1'b0);
        wb(1, 32'hB1, 1'b0, 32'd0);
        idle();
        check("t4_no_commit_before_head", 32'(bus.commit_reg_id), 32'd0);
        wb(0, 32'hB0, 1'b0, 32'd0);
        settle();

        // 5: lookup bypass and persistence after retire
        do_reset();
        issue(5'd1, 1'b0);
        issue(5'd2, 1'b0);
        issue(5'd3, 1'b0);
        cyc(1'b1, 1'b0, 5'd0, 1'b0, 2, 32'd7, 1'b0, 32'd0, 3'd2, 3'd2);
        wb(0, 32'h10, 1'b0, 32'd0);
        wb(1, 32'h11, 1'b0, 32'd0);
        settle();
        cyc(1'b1, 1'b0, 5'd0, 1'b0, -1, 32'd0, 1'b0, 32'd0, 3'd2, 3'd0);

        // 6: mispredicted branch flushes the younger op
        do_reset();
        issue(5'd1, 1'b1);
        issue(5'd2, 1'b0);
        wb(1, 32'h55, 1'b0, 32'd0);
        wb(0, 32'h99, 1'b1, 32'h80);
        wait_cnt = 0;
        while (!bus.clear && wait_cnt < 10) begin
            idle();
            wait_cnt++;
        end
        check("t6_clear_seen", 32'(bus.clear), 32'd1);
        check("t6_full_in_clear", 32'(bus.full), 32'd0);
        check("t6_issue_rob_id", 32'(bus.issue_rob_id), 32'd0);
        idle();
        check("t6_clear_one_cycle", 32'(bus.clear), 32'd0);
        check("t6_full_after_clear", 32'(bus.full), 32'd0);
        settle();

        // Randomized traffic with stalls, branches and flushes
        do_reset();
        wait_cnt = 0;
        for (int n = 0; n < 1500; n++) begin
            cand.delete();
            mpk = live.size();
            if (mp_pending) begin
                for (int i = 0; i < live.size(); i++) begin
                    if (live[i].done && live[i].mp) begin
                        mpk = i;
                        break;
                    end
                end
            end
            if (!stop_retire) begin
                for (int i = 0; i < mpk; i++) if (!live[i].done) cand.push_back(i);
            end
            widx = (cand.size() > 0 && $urandom_range(0, 2) != 0)
                   ? cand[$urandom_range(0, cand.size() - 1)] : -1;
            iv = !mp_pending && ($urandom_range(0, 1) == 1);
            cyc(($urandom_range(0, 9) != 0), iv, 5'($urandom_range(1, 31)),
                ($urandom_range(0, 3) == 0), widx, $urandom, ($urandom_range(0, 2) == 0),
                $urandom, (widx >= 0 && $urandom_range(0, 1) == 1) ? live[widx].id : 3'($urandom),
                3'($urandom));
            if (mp_pending) wait_cnt++;
            else wait_cnt = 0;
            if (wait_cnt > 150) begin
                vectors++;
                miscompares++;
                $display("FAIL flush_timeout: got no clear within 150 cycles, want clear");
                do_reset();
                wait_cnt = 0;
            end
        end
        mp_pending = mp_pending;
        if (!mp_pending) drain();
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
